// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Every bit, including start and stop, is held for the prescale value captured at accept.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line high, not busy, waiting for data_valid
//   S_START  | start bit (0) on the line
//   S_DATA   | data bit r_idx on the line; r_shift[0] holds that bit
//   S_PARITY | parity bit on the line
//   S_STOP   | stop bit (1); last edge returns to S_IDLE and drops busy
module uart_tx_frame #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     p_data,
    input  logic                      data_valid,
    input  logic                      par_en,
    input  logic                      par_typ,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tx_out,
    output logic                      busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_tx;
    logic                      w_tx_nxt;
    logic                      r_busy;
    logic                      w_busy_nxt;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic [DATA_WIDTH-1:0]     w_shifted;
    logic                      r_par_en;
    logic                      r_parity;
    logic [PRESCALE_WIDTH-1:0] r_cyc;
    logic [PRESCALE_WIDTH-1:0] r_cyc_last;
    logic [IDX_W-1:0]          r_idx;
    logic                      w_accept;
    logic                      w_bit_end;
    logic                      w_last_bit;

    assign w_accept   = (r_state == S_IDLE) && data_valid;
    assign w_bit_end  = (r_cyc == r_cyc_last);
    assign w_last_bit = (r_idx == IDX_W'(DATA_WIDTH - 1));
    assign w_shifted  = r_shift >> 1;

    assign tx_out = r_tx;
    assign busy   = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_tx_nxt    = r_tx;
        w_busy_nxt  = r_busy;
        unique case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (!w_last_bit) begin
                        w_tx_nxt = w_shifted[0];
                    end else if (r_par_en) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = r_parity;
                    end else begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_cyc      <= '0;
            r_cyc_last <= '0;
            r_idx      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;

            // A prescale of 0 behaves as 1, so the terminal count is 0 in both cases.
            if (w_accept) begin
                r_shift    <= p_data;
                r_par_en   <= par_en;
                r_parity   <= (^p_data) ^ par_typ;
                r_cyc_last <= (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
                r_idx      <= '0;
            end else if ((r_state == S_DATA) && w_bit_end) begin
                r_shift <= w_shifted;
                r_idx   <= r_idx + IDX_W'(1);
            end

            if ((r_state == S_IDLE) || w_bit_end) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: each frame is compared cycle by cycle against a bit list
// built from the frame format, with every bit repeated for the effective prescale.
module tb_uart_tx_frame;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic [PW-1:0] prescale;
    logic          tx_out;
    logic          busy;

    int total = 0;
    int bad   = 0;

    uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .prescale   (prescale),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Send one frame and follow it to the first idle sample after busy falls.
    // keep_valid leaves data_valid high for a back-to-back follower;
    // disturb pulses data_valid and scrambles every input partway through.
    task automatic run_frame(input string name, input logic [DW-1:0] d, input bit pe,
                             input bit pt, input logic [PW-1:0] ps,
                             input bit keep_valid, input bit disturb);
        bit q[$];
        int p_eff;
        int len;
        int busy_cnt;
        p_eff = (ps == 0) ? 1 : int'(ps);
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) q.push_back(d[i]);
        if (pe) q.push_back(((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ pt);
        q.push_back(1'b1);
        len      = q.size() * p_eff;
        busy_cnt = 0;

        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        prescale   = ps;
        data_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            total++;
            if ({busy, tx_out} !== {1'b1, q[k / p_eff]}) begin
                bad++;
                if (bad <= 40)
                    $display("FAIL %s cyc=%0d busy/tx got %b%b want 1%b", name, k, busy, tx_out, q[k / p_eff]);
            end
            if (busy === 1'b1) busy_cnt++;
            if ((k == 0) && !keep_valid) data_valid = 1'b0;
            if (disturb && (k == len / 3)) begin
                data_valid = 1'b1;
                p_data     = ~d;
                prescale   = ps + PW'(3);
                par_en     = ~pe;
                par_typ    = ~pt;
            end
            if (disturb && (k == len / 3 + 2)) data_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        total++;
        if ({busy, tx_out} !== 2'b01) begin
            bad++;
            $display("FAIL %s_end busy/tx got %b%b want 01", name, busy, tx_out);
        end
        total++;
        if (busy_cnt !== len) begin
            bad++;
            $display("FAIL %s_busy_len got %0d want %0d", name, busy_cnt, len);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, tx_out} !== 2'b01) begin
            bad++;
            $display("FAIL reset_hold busy/tx got %b%b want 01", busy, tx_out);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 4) rst = 1'b1;
            if (k == 6) rst = 1'b0;
            total++;
            if ({busy, tx_out} !== 2'b01) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d busy/tx got %b%b want 01", k, busy, tx_out);
            end
        end
    endtask

    task automatic test_even_parity();
        run_frame("even_a5", 8'hA5, 1'b1, 1'b0, 6'd4, 1'b0, 1'b0);
    endtask

    task automatic test_odd_parity();
        run_frame("odd_07", 8'h07, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0);
        run_frame("nopar_07", 8'h07, 1'b0, 1'b1, 6'd8, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        run_frame("busy_3c", 8'h3C, 1'b1, 1'b0, 6'd3, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_55", 8'h55, 1'b1, 1'b0, 6'd2, 1'b1, 1'b0);
        run_frame("b2b_aa", 8'hAA, 1'b1, 1'b0, 6'd2, 1'b0, 1'b0);
        run_frame("p0_first", 8'h9E, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
        run_frame("p0_second", 8'h31, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic test_max_prescale();
        run_frame("pmax", 8'hC3, 1'b1, 1'b1, 6'h3F, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        d          = DW'($urandom);
        p_data     = d;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        prescale   = 6'd4;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        total++;
        if (tx_out !== d[3]) begin
            bad++;
            $display("FAIL rst_mid_bit3 tx got %b want %b", tx_out, d[3]);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({busy, tx_out} !== 2'b01) begin
            bad++;
            $display("FAIL rst_mid_async busy/tx got %b%b want 01", busy, tx_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({busy, tx_out} !== 2'b01) begin
                bad++;
                $display("FAIL rst_mid_idle cyc=%0d busy/tx got %b%b want 01", k, busy, tx_out);
            end
        end
        run_frame("rst_mid_fresh", DW'($urandom), 1'b1, 1'b1, 6'd3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_frame($sformatf("rand%0d", n), DW'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), PW'($urandom_range(0, 6)),
                      1'b0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst        = 1'b1;
        p_data     = '0;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        prescale   = '0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_ignore_busy();
        test_back_to_back();
        test_max_prescale();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
